pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage NPC core. It merges per-stage stall requests into the shared stall vector consumed by every pipeline register (pc, if_id, id_ex, ex_ls, ls_wb, wb) and generates the per-register flush vector. It also sequences PC redirects for taken branches and traps, and drains any outstanding LSU memory transaction before a trap flushes the pipe.

---
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, flushes and redirects on branches and traps.
// Optional stall watchdog is built when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl #(
  parameter int STALL_W  = 6,
  parameter int ADDR_W   = 32,
  parameter int WDOG_MAX = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_stall_req,
  input  logic               id_stall_req,
  input  logic               ex_stall_req,
  input  logic               ls_stall_req,
  input  logic               ls_busy,
  input  logic               br_taken_i,
  input  logic [ADDR_W-1:0]  br_target_i,
  input  logic               trap_req_i,
  input  logic [ADDR_W-1:0]  trap_vec_i,
  output logic [STALL_W-1:0] stall_o,
  output logic [STALL_W-1:0] flush_o,
  output logic               redirect_o,
  output logic [ADDR_W-1:0]  redirect_pc_o,
  output logic               trap_ack_o,
  output logic               wdog_timeout_o
);

  localparam logic [STALL_W-1:0] MASK_IF    = STALL_W'(6'b000011);
  localparam logic [STALL_W-1:0] MASK_ID    = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] MASK_EX    = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] MASK_LS    = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] FLUSH_BR   = STALL_W'(6'b000110);
  localparam logic [STALL_W-1:0] FLUSH_TRAP = STALL_W'(6'b011110);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] vec_q;

  logic [STALL_W-1:0] stall_raw;
  logic [STALL_W-1:0] stall_v;
  logic [STALL_W-1:0] flush_v;
  logic               redirect_v;
  logic [ADDR_W-1:0]  redirect_pc_v;
  logic               ack_v;

  // Trap sequencing: wait out any LSU bus transaction before the flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_req_i) begin
            vec_q <= trap_vec_i;
            state <= ls_busy ? DRAIN : FLUSH;
          end
        end
        DRAIN: begin
          if (!ls_busy) state <= FLUSH;
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_raw = '0;
    if (if_stall_req) stall_raw = stall_raw | MASK_IF;
    if (id_stall_req) stall_raw = stall_raw | MASK_ID;
    if (ex_stall_req) stall_raw = stall_raw | MASK_EX;
    if (ls_stall_req) stall_raw = stall_raw | MASK_LS;

    stall_v       = stall_raw;
    flush_v       = '0;
    redirect_v    = 1'b0;
    redirect_pc_v = '0;
    ack_v         = 1'b0;
    case (state)
      IDLE: begin
        if (!trap_req_i && br_taken_i) begin
          flush_v       = FLUSH_BR;
          redirect_v    = 1'b1;
          redirect_pc_v = br_target_i;
        end
      end
      DRAIN: stall_v = stall_raw | MASK_EX;
      FLUSH: begin
        stall_v       = '0;
        flush_v       = FLUSH_TRAP;
        redirect_v    = 1'b1;
        redirect_pc_v = vec_q;
        ack_v         = 1'b1;
      end
      default: ;
    endcase
  end

  // Combinational outputs are gated by reset as well, so they read zero during reset.
  assign stall_o       = rst_n ? (stall_v & ~flush_v) : '0;
  assign flush_o       = rst_n ? flush_v : '0;
  assign redirect_o    = rst_n & redirect_v;
  assign redirect_pc_o = rst_n ? redirect_pc_v : '0;
  assign trap_ack_o    = rst_n & ack_v;

`ifdef PIPE_CTRL_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_MAX + 1);
  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_MAX);

  logic [CNT_W-1:0] wdog_cnt;
  logic [CNT_W-1:0] wdog_cnt_next;
  logic             wdog_flag;

  always_comb begin
    wdog_cnt_next = '0;
    if (stall_o[0] && !redirect_o)
      wdog_cnt_next = (wdog_cnt == WDOG_LIM) ? wdog_cnt : wdog_cnt + CNT_W'(1);
  end

  // Flag sets on the same edge the counter reaches the limit and is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt  <= '0;
      wdog_flag <= 1'b0;
    end else begin
      wdog_cnt <= wdog_cnt_next;
      if (wdog_cnt_next == WDOG_LIM) wdog_flag <= 1'b1;
    end
  end

  assign wdog_timeout_o = rst_n & wdog_flag;
`else
  logic unused_wdog;
  assign unused_wdog    = ^WDOG_MAX;
  assign wdog_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; expectations follow PIPE_CTRL_WDOG_EN.
module tb_pipe_ctrl;
  localparam int STALL_W  = 6;
  localparam int ADDR_W   = 32;
  localparam int WDOG_MAX = 16;
`ifdef PIPE_CTRL_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               if_stall_req, id_stall_req, ex_stall_req, ls_stall_req;
  logic               ls_busy, br_taken_i, trap_req_i;
  logic [ADDR_W-1:0]  br_target_i, trap_vec_i;
  logic [STALL_W-1:0] stall_o, flush_o;
  logic               redirect_o, trap_ack_o, wdog_timeout_o;
  logic [ADDR_W-1:0]  redirect_pc_o;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_ctrl #(.STALL_W(STALL_W), .ADDR_W(ADDR_W), .WDOG_MAX(WDOG_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .ex_stall_req(ex_stall_req), .ls_stall_req(ls_stall_req),
    .ls_busy(ls_busy), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .trap_req_i(trap_req_i), .trap_vec_i(trap_vec_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .trap_ack_o(trap_ack_o),
    .wdog_timeout_o(wdog_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ifs, input logic ids, input logic exs,
                               input logic lss, input logic busy, input logic br,
                               input logic [ADDR_W-1:0] brt, input logic trap,
                               input logic [ADDR_W-1:0] vec);
    if_stall_req = ifs;
    id_stall_req = ids;
    ex_stall_req = exs;
    ls_stall_req = lss;
    ls_busy      = busy;
    br_taken_i   = br;
    br_target_i  = brt;
    trap_req_i   = trap;
    trap_vec_i   = vec;
  endtask

  task automatic checkOutput(input string tag, input logic [STALL_W-1:0] e_stall,
                             input logic [STALL_W-1:0] e_flush, input logic e_redir,
                             input logic [ADDR_W-1:0] e_pc, input logic e_ack,
                             input logic e_wdog);
    logic [2*STALL_W+ADDR_W+2:0] obs, exp;
    obs = {stall_o, flush_o, redirect_o, redirect_pc_o, trap_ack_o, wdog_timeout_o};
    exp = {e_stall, e_flush, e_redir, e_pc, e_ack, e_wdog};
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got stall=%b flush=%b redir=%b pc=%h ack=%b wdog=%b, expected stall=%b flush=%b redir=%b pc=%h ack=%b wdog=%b",
             tag, stall_o, flush_o, redirect_o, redirect_pc_o, trap_ack_o, wdog_timeout_o,
             e_stall, e_flush, e_redir, e_pc, e_ack, e_wdog);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 1, 32'h1234_5678, 0, 0);
    #1 checkOutput("reset_forced_zero", 6'b0, 6'b0, 0, 32'h0, 0, 0);

    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("idle_quiet", 6'b0, 6'b0, 0, 32'h0, 0, 0);

    @(negedge clk);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("stall_id_ls", 6'b011111, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("stall_if", 6'b000011, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("stall_ex", 6'b001111, 6'b0, 0, 32'h0, 0, 0);

    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0100, 0, 0);
    #1 checkOutput("branch", 6'b0, 6'b000110, 1, 32'h8000_0100, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h8000_0180, 0, 0);
    #1 checkOutput("branch_flush_over_stall", 6'b000001, 6'b000110, 1, 32'h8000_0180, 0, 0);

    // Fast trap with a simultaneous branch that must be dropped.
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1111_0000, 1, 32'h8000_0004);
    #1 checkOutput("trap_T_branch_dropped", 6'b0, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 32'h0);
    #1 checkOutput("trap_T1_flush", 6'b0, 6'b011110, 1, 32'h8000_0004, 1, 0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("trap_T2_idle_stall_back", 6'b000111, 6'b0, 0, 32'h0, 0, 0);

    // Trap that drains three cycles of LSU traffic first.
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0200);
    #1 checkOutput("drain_T", 6'b0, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h2222_0000, 1, 32'hDEAD_BEEF);
    #1 checkOutput("drain_T1_branch_ignored", 6'b001111, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    #1 checkOutput("drain_T2_ls_stall", 6'b011111, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    #1 checkOutput("drain_T3_last", 6'b001111, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    #1 checkOutput("drain_T4_ack", 6'b0, 6'b011110, 1, 32'h8000_0200, 1, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("drain_T5_idle", 6'b0, 6'b0, 0, 32'h0, 0, 0);

    // Reset in the middle of a drain abandons the trap.
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0300);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0300);
    #1 checkOutput("rst_pre_drain", 6'b001111, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0300);
    #1 checkOutput("rst_mid_drain", 6'b0, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("rst_no_ack", 6'b0, 6'b0, 0, 32'h0, 0, 0);
      @(negedge clk);
    end

    // Watchdog: fetch stall held across WDOG_MAX edges.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (15) @(negedge clk);
    #1 checkOutput("wdog_15", 6'b000011, 6'b0, 0, 32'h0, 0, 0);
    @(negedge clk);
    #1 checkOutput("wdog_16", 6'b000011, 6'b0, 0, 32'h0, 0, WDOG_EN);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 checkOutput("wdog_sticky", 6'b0, 6'b0, 0, 32'h0, 0, WDOG_EN);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
